// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the round-robin UART transmit scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: sched_state_t (FSM states), TAG_BASE (tag byte prefix), DATA_W (byte width).
// Build option: UART_TX_SCHED_TAG_EN adds the ISSUE_D state used for tag-then-data frames.
package uart_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] TAG_BASE = 8'hA0;

`ifdef UART_TX_SCHED_TAG_EN
  typedef enum logic [2:0] {
    SYNC     = 3'd0,
    IDLE     = 3'd1,
    ISSUE    = 3'd2,
    WAIT_ACT = 3'd3,
    WAIT_END = 3'd4,
    ISSUE_D  = 3'd5
  } sched_state_t;
`else
  typedef enum logic [2:0] {
    SYNC     = 3'd0,
    IDLE     = 3'd1,
    ISSUE    = 3'd2,
    WAIT_ACT = 3'd3,
    WAIT_END = 3'd4
  } sched_state_t;
`endif

endpackage

// File: rtl/uart_rr_arbiter.sv
// Purpose: combinational round-robin pick of the first requester at or above ptr (wrapping).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when a grant is taken.
// Ports: req (request vector), ptr (search start), grant_onehot / grant_id (winner), any (some req set).
module uart_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant_onehot,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     any
);

  localparam int ID_W = $clog2(N_REQ);

  always_comb begin
    grant_onehot = '0;
    grant_id     = '0;
    any          = 1'b0;
    // Walk N_REQ positions starting at ptr; the first hit wins and later hits are ignored.
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[(int'(ptr) + i) % N_REQ]) begin
        any      = 1'b1;
        grant_id = ID_W'((int'(ptr) + i) % N_REQ);
      end
    end
    if (any) begin
      grant_onehot[grant_id] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Purpose: shares one uartTX between N_REQ byte producers with round-robin arbitration.
// Latency: accept registered at the IDLE edge, o_tx_dv in the same following cycle; 10*CLK_PER_BIT+3 accept-to-accept.
// Backpressure: requesters hold valid until their one-cycle ready pulse; issue is paced by i_tx_active.
// Ports: clk, rst (async, active-high); i_req_valid/i_req_byte in, o_req_ready/o_grant_id out;
//        o_busy (not IDLE), o_err (sticky watchdog); o_tx_dv/o_tx_byte to uartTX, i_tx_active from uartTX.
// Build option: UART_TX_SCHED_TAG_EN sends a tag byte (TAG_BASE | id) ahead of each data byte.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WD_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*DATA_W-1:0]  i_req_byte,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_busy,
  output logic                     o_err,
  output logic                     o_tx_dv,
  output logic [DATA_W-1:0]        o_tx_byte,
  input  logic                     i_tx_active
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int WD_W = $clog2(WD_CYCLES + 1);
  // WAIT_ACT is entered one edge after the issue edge, so the timeout fires on
  // the (WD_CYCLES-1)th WAIT_ACT edge, i.e. WD_CYCLES edges after o_tx_dv rose.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 2);

  sched_state_t        state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [N_REQ-1:0]    ready_q, ready_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                dv_q, dv_d;
  logic [WD_W-1:0]     wd_q, wd_d;
`ifdef UART_TX_SCHED_TAG_EN
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   byte_q, byte_d;
`endif

  logic [N_REQ-1:0]    arb_onehot;
  logic [ID_W-1:0]     arb_id;
  logic                arb_any;

  uart_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req          (i_req_valid),
    .ptr          (ptr_q),
    .grant_onehot (arb_onehot),
    .grant_id     (arb_id),
    .any          (arb_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    ready_d = '0;
    gid_d   = gid_q;
    err_d   = err_q;
    dv_d    = 1'b0;
    wd_d    = wd_q;
`ifdef UART_TX_SCHED_TAG_EN
    pend_d  = pend_q;
    byte_d  = byte_q;
`endif

    case (state_q)
      // uartTX has no reset and may still be mid-frame; wait for it to go quiet.
      SYNC: begin
        if (!i_tx_active) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (arb_any) begin
          hold_d  = i_req_byte[int'(arb_id)*DATA_W +: DATA_W];
          gid_d   = arb_id;
          ready_d = arb_onehot;
          ptr_d   = (int'(arb_id) == N_REQ - 1) ? '0 : arb_id + 1'b1;
          dv_d    = 1'b1;
          state_d = ISSUE;
`ifdef UART_TX_SCHED_TAG_EN
          byte_d  = TAG_BASE | DATA_W'(arb_id);
          pend_d  = 1'b1;
`endif
        end
      end

      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT_ACT;
      end

      WAIT_ACT: begin
        if (i_tx_active) begin
          state_d = WAIT_END;
        end else if (wd_q == WD_LAST) begin
          // Transmitter never started: flag it and drop the grant (both frames in tag mode).
          err_d   = 1'b1;
          state_d = IDLE;
`ifdef UART_TX_SCHED_TAG_EN
          pend_d  = 1'b0;
`endif
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      WAIT_END: begin
        if (!i_tx_active) begin
`ifdef UART_TX_SCHED_TAG_EN
          if (pend_q) begin
            dv_d    = 1'b1;
            byte_d  = hold_q;
            pend_d  = 1'b0;
            state_d = ISSUE_D;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end

`ifdef UART_TX_SCHED_TAG_EN
      ISSUE_D: begin
        wd_d    = '0;
        state_d = WAIT_ACT;
      end
`endif

      default: begin
        state_d = SYNC;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SYNC;
      ptr_q   <= '0;
      hold_q  <= '0;
      ready_q <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
      wd_q    <= '0;
`ifdef UART_TX_SCHED_TAG_EN
      pend_q  <= 1'b0;
      byte_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      dv_q    <= dv_d;
      wd_q    <= wd_d;
`ifdef UART_TX_SCHED_TAG_EN
      pend_q  <= pend_d;
      byte_q  <= byte_d;
`endif
    end
  end

  assign o_req_ready = ready_q;
  assign o_grant_id  = gid_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;
  assign o_tx_dv     = dv_q;
`ifdef UART_TX_SCHED_TAG_EN
  assign o_tx_byte   = byte_q;
`else
  // Without tags the latched request byte is the only thing ever transmitted.
  assign o_tx_byte   = hold_q;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Purpose: self-checking bench for uart_tx_scheduler with a behavioural uartTX (CLK_PER_BIT=4) and serial decoder.
// Latency: n/a.
// Backpressure: requesters hold valid until their ready pulse, as a real producer would.
module tb_uart_tx_scheduler;

  localparam int N      = 4;
  localparam int CPB    = 4;
  localparam int PERIOD = 10 * CPB + 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   i_req_valid = '0;
  logic [N*8-1:0] i_req_byte = '0;
  logic [N-1:0]   o_req_ready;
  logic [1:0]     o_grant_id;
  logic           o_busy;
  logic           o_err;
  logic           o_tx_dv;
  logic [7:0]     o_tx_byte;
  logic           i_tx_active;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ref_ptr = 0;

  uart_tx_scheduler #(.N_REQ(N), .WD_CYCLES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .i_req_byte  (i_req_byte),
    .o_req_ready (o_req_ready),
    .o_grant_id  (o_grant_id),
    .o_busy      (o_busy),
    .o_err       (o_err),
    .o_tx_dv     (o_tx_dv),
    .o_tx_byte   (o_tx_byte),
    .i_tx_active (i_tx_active)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Behavioural uartTX: no reset, IDLE -> 10*CPB cycles of frame -> one CLEANUP cycle.
  logic       stub_mode = 1'b0;
  int         m_st = 0;
  int         m_cnt = 0;
  logic [7:0] m_dat = '0;
  logic       m_active = 1'b0;
  logic       tx_serial;

  always @(posedge clk) begin
    case (m_st)
      0: if (o_tx_dv === 1'b1 && !stub_mode) begin
           m_active <= 1'b1; m_dat <= o_tx_byte; m_cnt <= 0; m_st <= 1;
         end
      1: if (m_cnt == 10 * CPB - 1) begin m_active <= 1'b0; m_st <= 2; end
         else m_cnt <= m_cnt + 1;
      default: m_st <= 0;
    endcase
  end

  always_comb begin
    tx_serial = 1'b1;
    if (m_st == 1) begin
      if (m_cnt / CPB == 0) tx_serial = 1'b0;
      else if (m_cnt / CPB <= 8) tx_serial = m_dat[m_cnt / CPB - 1];
    end
  end

  assign i_tx_active = stub_mode ? 1'b0 : m_active;

  // Serial decoder: frame bit 0 = start, bits 8:1 = data LSB first, bit 9 = stop.
  logic [9:0] rx_q[$];
  logic [9:0] rx_f;
  initial forever begin
    @(negedge clk);
    if (tx_serial === 1'b0) begin
      rx_f = '0;
      for (int b = 1; b < 10; b++) begin
        repeat (CPB) @(negedge clk);
        rx_f[b] = tx_serial;
      end
      rx_q.push_back(rx_f);
    end
  end

  // Event monitor for pulse counts and timing.
  int   ready_cnt = 0, dv_cnt = 0, dv_double = 0, dv_busy = 0;
  int   last_dv_cyc = 0, err_rise_cyc = -100;
  logic prev_dv = 1'b0, prev_err = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rst === 1'b0) begin
      if (o_req_ready !== '0) ready_cnt++;
      if (o_tx_dv === 1'b1) begin
        dv_cnt++;
        last_dv_cyc = cyc;
        if (prev_dv) dv_double++;
        if (m_st != 0 && !stub_mode) dv_busy++;
      end
      if (o_err === 1'b1 && !prev_err) err_rise_cyc = cyc;
    end
    prev_dv  = (o_tx_dv === 1'b1);
    prev_err = (o_err === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_ready(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (o_req_ready !== '0) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  // Reference arbitration rule: first valid requester at or after ptr, wrapping.
  function automatic int rr_pick(input logic [N-1:0] mask, input int p);
    for (int i = 0; i < N; i++) if (mask[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; i_req_valid = '0; i_req_byte = '0;
    tick(3);
    vectors++; if (o_req_ready !== 4'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0000", o_req_ready); end
    vectors++; if (o_grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_grant_id: got %0d want 0", o_grant_id); end
    vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b want 1", o_busy); end
    vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", o_err); end
    vectors++; if (o_tx_dv !== 1'b0) begin miscompares++; $display("FAIL reset_tx_dv: got %b want 0", o_tx_dv); end
    vectors++; if (o_tx_byte !== 8'h00) begin miscompares++; $display("FAIL reset_tx_byte: got %h want 00", o_tx_byte); end
    rst = 1'b0; ref_ptr = 0;
    tick(2);
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_sync_exit busy: got %b want 0", o_busy); end
  endtask

  task automatic test_single();
    bit ok; int r0, d0;
    logic [9:0] want;
    rx_q.delete(); r0 = ready_cnt; d0 = dv_cnt;
    i_req_byte = $urandom;
    i_req_byte[23:16] = 8'h5A;
    i_req_valid = 4'b0100;
    wait_ready(10, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL single_accept: got no ready want ready"); end
    vectors++; if (o_req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_ready: got %b want 0100", o_req_ready); end
    vectors++; if (o_grant_id !== 2'd2) begin miscompares++; $display("FAIL single_grant_id: got %0d want 2", o_grant_id); end
    vectors++; if (o_tx_dv !== 1'b1 || o_tx_byte !== 8'h5A) begin miscompares++; $display("FAIL single_issue: got dv=%b byte=%h want dv=1 byte=5a", o_tx_dv, o_tx_byte); end
    i_req_valid = '0;
    tick();
    vectors++; if (o_tx_dv !== 1'b0) begin miscompares++; $display("FAIL single_dv_width: got %b want 0", o_tx_dv); end
    for (int i = 0; i < 100 && rx_q.size() < 1; i++) tick();
    want = {1'b1, 8'h5A, 1'b0};
    vectors++;
    if (rx_q.size() < 1) begin miscompares++; $display("FAIL single_frame: got no frame want %b", want); end
    else if (rx_q[0] !== want) begin miscompares++; $display("FAIL single_frame: got %b want %b", rx_q[0], want); end
    for (int i = 0; i < 20 && o_busy !== 1'b0; i++) tick();
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end: got %b want 0", o_busy); end
    vectors++; if (ready_cnt - r0 != 1 || dv_cnt - d0 != 1) begin miscompares++; $display("FAIL single_pulses: got ready=%0d dv=%0d want 1 1", ready_cnt - r0, dv_cnt - d0); end
    ref_ptr = 3;
  endtask

  task automatic test_round_robin();
    bit ok; int exp_id, prev_cyc;
    logic [N-1:0] exp_oh;
    logic [7:0] exp_q[$];
    rst = 1'b1; tick(); rst = 1'b0; ref_ptr = 0; tick(2);
    rx_q.delete();
    prev_cyc = 0;
    i_req_byte = $urandom;
    i_req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_ready(PERIOD + 5, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rr_accept%0d: got no ready want ready", n); break; end
      exp_id = rr_pick(i_req_valid, ref_ptr);
      exp_oh = '0; exp_oh[exp_id] = 1'b1;
      vectors++; if (o_req_ready !== exp_oh || o_grant_id !== 2'(exp_id)) begin miscompares++; $display("FAIL rr_order%0d: got ready=%b id=%0d want ready=%b id=%0d", n, o_req_ready, o_grant_id, exp_oh, exp_id); end
      if (n > 0) begin
        vectors++; if (cyc - prev_cyc != PERIOD) begin miscompares++; $display("FAIL rr_spacing%0d: got %0d want %0d", n, cyc - prev_cyc, PERIOD); end
      end
      prev_cyc = cyc;
      exp_q.push_back(i_req_byte[exp_id*8 +: 8]);
      ref_ptr = (exp_id + 1) % N;
      i_req_byte[exp_id*8 +: 8] = 8'($urandom);
      if (n == 4) i_req_valid = '0;
      tick();
    end
    for (int i = 0; i < 5 * PERIOD && rx_q.size() < exp_q.size(); i++) tick();
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= rx_q.size()) begin miscompares++; $display("FAIL rr_byte%0d: got none want %h", i, exp_q[i]); end
      else if (rx_q[i][8:1] !== exp_q[i] || rx_q[i][9] !== 1'b1) begin miscompares++; $display("FAIL rr_byte%0d: got %h stop=%b want %h stop=1", i, rx_q[i][8:1], rx_q[i][9], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok; int exp_id, k, n_acc;
    logic [N-1:0] exp_oh;
    logic [7:0] exp_q[$];
    rx_q.delete(); n_acc = 0;
    i_req_valid = 4'($urandom_range(1, 15));
    i_req_byte = $urandom;
    for (int n = 0; n < 24; n++) begin
      wait_ready(PERIOD + 5, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rand_accept%0d: got no ready want ready", n); break; end
      exp_id = rr_pick(i_req_valid, ref_ptr);
      exp_oh = '0; exp_oh[exp_id] = 1'b1;
      vectors++; if (o_req_ready !== exp_oh || o_grant_id !== 2'(exp_id)) begin miscompares++; $display("FAIL rand_grant%0d: got ready=%b id=%0d want ready=%b id=%0d", n, o_req_ready, o_grant_id, exp_oh, exp_id); end
      exp_q.push_back(i_req_byte[exp_id*8 +: 8]);
      n_acc++;
      ref_ptr = (exp_id + 1) % N;
      // The served requester either drops or re-raises with a new byte in its own ready cycle.
      if ($urandom_range(0, 1) == 0) i_req_valid[exp_id] = 1'b0;
      else i_req_byte[exp_id*8 +: 8] = 8'($urandom);
      for (int j = 0; j < N; j++) begin
        if (!i_req_valid[j] && j != exp_id && $urandom_range(0, 2) == 0) begin
          i_req_byte[j*8 +: 8] = 8'($urandom); i_req_valid[j] = 1'b1;
        end
      end
      if (i_req_valid == '0) begin
        k = $urandom_range(0, N - 1);
        i_req_byte[k*8 +: 8] = 8'($urandom); i_req_valid[k] = 1'b1;
      end
      if (n == 23) i_req_valid = '0;
      tick();
    end
    for (int i = 0; i < 2 * PERIOD && rx_q.size() < n_acc; i++) tick();
    for (int i = 0; i < n_acc; i++) begin
      vectors++;
      if (i >= rx_q.size()) begin miscompares++; $display("FAIL rand_byte%0d: got none want %h", i, exp_q[i]); end
      else if (rx_q[i][8:1] !== exp_q[i]) begin miscompares++; $display("FAIL rand_byte%0d: got %h want %h", i, rx_q[i][8:1], exp_q[i]); end
    end
    vectors++; if (dv_double != 0 || dv_busy != 0) begin miscompares++; $display("FAIL dv_protocol: got double=%0d busy=%0d want 0 0", dv_double, dv_busy); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok; int d0;
    logic [7:0] b0, b1;
    for (int i = 0; i < 2 * PERIOD && o_busy !== 1'b0; i++) tick();
    rx_q.delete();
    b0 = 8'($urandom_range(1, 255)); b1 = 8'($urandom);
    i_req_byte[23:16] = b0; i_req_valid = 4'b0100;
    wait_ready(10, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rmf_accept: got no ready want ready"); end
    i_req_valid = '0;
    tick(15);
    #1 rst = 1'b1;
    #1;
    vectors++; if (o_grant_id !== 2'd0 || o_tx_byte !== 8'h00) begin miscompares++; $display("FAIL rmf_async_regs: got id=%0d byte=%h want 0 00", o_grant_id, o_tx_byte); end
    vectors++; if (o_busy !== 1'b1 || o_err !== 1'b0 || o_tx_dv !== 1'b0 || o_req_ready !== 4'b0) begin miscompares++; $display("FAIL rmf_async_ctl: got busy=%b err=%b dv=%b ready=%b want 1 0 0 0000", o_busy, o_err, o_tx_dv, o_req_ready); end
    tick(2);
    rst = 1'b0; ref_ptr = 0;
    d0 = dv_cnt;
    i_req_byte[15:8] = b1; i_req_valid = 4'b0010;
    tick();
    vectors++; if (o_busy !== 1'b1 || o_req_ready !== 4'b0) begin miscompares++; $display("FAIL rmf_sync_hold: got busy=%b ready=%b want 1 0000", o_busy, o_req_ready); end
    for (int i = 0; i < 60 && m_active; i++) tick();
    vectors++; if (dv_cnt != d0) begin miscompares++; $display("FAIL rmf_no_dv_in_sync: got %0d pulses want 0", dv_cnt - d0); end
    wait_ready(10, ok);
    vectors++; if (!ok || o_req_ready !== 4'b0010) begin miscompares++; $display("FAIL rmf_reaccept: got %b want 0010", o_req_ready); end
    i_req_valid = '0;
    ref_ptr = 2;
    for (int i = 0; i < 2 * PERIOD && rx_q.size() < 2; i++) tick();
    vectors++; if (rx_q.size() < 2 || rx_q[0] !== {1'b1, b0, 1'b0} || rx_q[1] !== {1'b1, b1, 1'b0}) begin
      miscompares++; $display("FAIL rmf_frames: got %0d frames want %b %b", rx_q.size(), {1'b1, b0, 1'b0}, {1'b1, b1, 1'b0});
    end
  endtask

  task automatic test_watchdog();
    bit ok; int k, exp_id;
    logic [N-1:0] exp_oh;
    for (int i = 0; i < 4 * PERIOD && o_busy !== 1'b0; i++) tick();
    tick(3);
    rx_q.delete();
    stub_mode = 1'b1;
    k = $urandom_range(0, N - 1);
    i_req_byte[k*8 +: 8] = 8'($urandom); i_req_valid[k] = 1'b1;
    wait_ready(10, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wd_accept: got no ready want ready"); end
    i_req_valid = '0;
    ref_ptr = (k + 1) % N;
    for (int i = 0; i < 10 && o_err !== 1'b1; i++) tick();
    vectors++; if (o_err !== 1'b1) begin miscompares++; $display("FAIL wd_err: got %b want 1", o_err); end
    vectors++; if (err_rise_cyc - last_dv_cyc != 3) begin miscompares++; $display("FAIL wd_err_delay: got %0d want 3", err_rise_cyc - last_dv_cyc); end
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL wd_to_idle: got busy=%b want 0", o_busy); end
    i_req_valid = 4'($urandom_range(1, 15));
    exp_id = rr_pick(i_req_valid, ref_ptr);
    wait_ready(5, ok);
    exp_oh = '0; exp_oh[exp_id] = 1'b1;
    vectors++; if (!ok || o_req_ready !== exp_oh) begin miscompares++; $display("FAIL wd_reaccept: got %b want %b", o_req_ready, exp_oh); end
    i_req_valid = '0;
    ref_ptr = (exp_id + 1) % N;
    vectors++; if (o_err !== 1'b1) begin miscompares++; $display("FAIL wd_sticky: got %b want 1", o_err); end
    for (int i = 0; i < 10 && o_busy !== 1'b0; i++) tick();
    stub_mode = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0; ref_ptr = 0; tick(2);
    vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL wd_err_clear: got %b want 0", o_err); end
    vectors++; if (rx_q.size() != 0) begin miscompares++; $display("FAIL wd_no_frames: got %0d want 0", rx_q.size()); end
  endtask

`ifdef UART_TX_SCHED_TAG_EN
  task automatic test_tag();
    bit ok; int r0, d0, gid_bad;
    rx_q.delete(); r0 = ready_cnt; d0 = dv_cnt; gid_bad = 0;
    i_req_byte[31:24] = 8'h11; i_req_valid = 4'b1000;
    wait_ready(10, ok);
    vectors++; if (!ok || o_req_ready !== 4'b1000 || o_grant_id !== 2'd3) begin miscompares++; $display("FAIL tag_accept: got ready=%b id=%0d want 1000 3", o_req_ready, o_grant_id); end
    vectors++; if (o_tx_byte !== 8'hA3 || o_tx_dv !== 1'b1) begin miscompares++; $display("FAIL tag_issue: got dv=%b byte=%h want 1 a3", o_tx_dv, o_tx_byte); end
    i_req_valid = '0;
    ref_ptr = 0;
    for (int i = 0; i < 4 * PERIOD && o_busy !== 1'b0; i++) begin
      if (o_grant_id !== 2'd3) gid_bad++;
      tick();
    end
    vectors++; if (gid_bad != 0 || o_busy !== 1'b0) begin miscompares++; $display("FAIL tag_grant_hold: got %0d bad cycles busy=%b want 0 0", gid_bad, o_busy); end
    vectors++; if (ready_cnt - r0 != 1 || dv_cnt - d0 != 2) begin miscompares++; $display("FAIL tag_pulses: got ready=%0d dv=%0d want 1 2", ready_cnt - r0, dv_cnt - d0); end
    for (int i = 0; i < PERIOD && rx_q.size() < 2; i++) tick();
    vectors++; if (rx_q.size() < 2 || rx_q[0][8:1] !== 8'hA3 || rx_q[1][8:1] !== 8'h11) begin miscompares++; $display("FAIL tag_frames: got %0d frames want a3 11", rx_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef UART_TX_SCHED_TAG_EN
    test_tag();
`else
    test_single();
    test_round_robin();
    test_random();
    test_reset_mid_frame();
`endif
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
